// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev
//
// Memory-mapped countdown timer. This is the responder end of the data-memory
// access path: it only ever sees legal, already-qualified word accesses.
// Word offsets: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved (reads 0).
//
// CTRL layout: [0] Enable, [2:1] Mode, [3] IM (interrupt mask), [31:4] read 0.
//
// Build option:
//   TIMER_MODE1_EN  defined   -> Mode 1 auto-reloads PRESET after each expiry.
//                   undefined -> every mode behaves as one-shot (Mode 0); the
//                                Mode field is still stored and read back.
//
// Ports:
//   clk    in   1   system clock, all state on rising edge
//   reset  in   1   asynchronous active-low reset, clears all state
//   Addr   in   2   word offset within the device window
//   WE     in   1   word write strobe (pre-qualified upstream)
//   WData  in  32   write data
//   RData  out 32   combinational read data for Addr
//   IRQ    out  1   interrupt request = irq_flag & CTRL.IM
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | stopped; COUNT frozen; leaves when Enable=1
//   ST_LOAD | COUNT <= PRESET
//   ST_CNT  | counting down; Enable=0 stops, COUNT<=1 expires into ST_INT
//   ST_INT  | expired; one-shot clears Enable, auto-reload re-enters LOAD
// ---------------------------------------------------------------------------
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] WData,
   output logic [31:0] RData,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   state_t      state;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        enable;
   logic        reload_mode;
   logic        count_done;
   logic        flag_set;
   logic        flag_reload_clr;

   assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
   assign wr_preset = WE && (Addr == ADDR_PRESET);
   assign enable    = ctrl[0];

`ifdef TIMER_MODE1_EN
   assign reload_mode = (ctrl[2:1] == 2'b01);
`else
   assign reload_mode = 1'b0;
`endif

   // Terminal check at <=1 so that PRESET=0 and PRESET=1 both expire without
   // ever decrementing below zero.
   assign count_done = (count <= 32'd1);

   assign flag_set        = (state == ST_CNT) && enable && count_done;
   assign flag_reload_clr = (state == ST_INT) && reload_mode;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable)
                  state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (count_done) begin
                  count <= 32'd0;
                  state <= ST_INT;
               end else begin
                  count <= count - 32'd1;
               end
            end
            ST_INT: begin
               if (reload_mode) begin
                  state <= ST_LOAD;
               end else begin
                  ctrl[0] <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Placed after the FSM so a CPU write to CTRL overrides the
         // one-shot Enable clear in the same cycle.
         if (wr_ctrl)
            ctrl <= WData[3:0];
         if (wr_preset)
            preset <= WData;

         // Expiry beats an acknowledge landing in the same cycle, otherwise
         // the interrupt would be lost.
         if (flag_set)
            irq_flag <= 1'b1;
         else if (wr_ctrl || wr_preset || flag_reload_clr)
            irq_flag <= 1'b0;
      end
   end

   always_comb begin
      RData = 32'd0;
      case (Addr)
         ADDR_CTRL:   RData = {28'd0, ctrl};
         ADDR_PRESET: RData = preset;
         ADDR_COUNT:  RData = count;
         default:     RData = 32'd0;
      endcase
   end

   assign IRQ = irq_flag & ctrl[3];

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds to word loads/stores in the 0x7f00–0x7f0b / 0x7f10–0x7f1b device windows (one instance per window). It is the responder end of the data-memory access path: address decoding, alignment and width errors (AdEL/AdES) are resolved upstream in the memory stage, so this block sees only legal word accesses. It owns CTRL/PRESET/COUNT registers, a 4-state counting FSM, and drives one interrupt line into the CP0 hardware-interrupt vector.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `Addr`  in  2  word offset within window (Addr[3:2] of bus address): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- `WE`  in  1  word write strobe, already qualified by window select and no exception
- `WData`  in  32  write data
- `RData`  out  32  combinational read data for `Addr`
- `IRQ`  out  1  interrupt request = irq_flag & CTRL.IM

## Operation
- CTRL: [0] Enable, [2:1] Mode, [3] IM, [31:4] read 0. Write: CTRL <= {28'b0, WData[3:0]}.
- PRESET: full 32-bit R/W. COUNT: read-only, writes ignored. Addr 3: reads 0, writes ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so IRQ=0, RData = value at Addr (0 for all).
- FSM:
  - IDLE: Enable=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: Enable=0 -> IDLE (COUNT frozen). Else COUNT>1: COUNT <= COUNT-1. Else (COUNT ≤ 1, incl. PRESET=0): COUNT <= 0, irq_flag <= 1, -> INT.
  - INT, Mode 0: CTRL.Enable <= 0, -> IDLE; irq_flag held.
  - INT, Mode 1: irq_flag <= 0, -> LOAD (auto-reload).
  - Modes 2/3 behave as Mode 0.
- irq_flag cleared by any write to CTRL or PRESET (Mode 0 acknowledge).
- Decrement is unsigned 32-bit; no wrap below 0 (terminal check at ≤1).
- Simultaneous events: CPU write to CTRL in the INT cycle wins over the FSM clearing Enable; CPU write clearing irq_flag in the same cycle the FSM sets it: set wins. PRESET write during CNT does not alter COUNT until next LOAD.
- Enable cleared while in LOAD or INT: state proceeds one step, then IDLE from CNT/LOAD rules (LOAD still loads COUNT).

## Timing
- Register writes take effect at the edge where WE=1; RData reflects the new value the next cycle.
- Write Enable=1 at edge E0 with PRESET=P≥1: LOAD after E0, COUNT=P after E1+1 (edge E2), COUNT=1 at E2+P-1, INT + irq_flag=1 at E2+P. IRQ rises P+2 edges after E0.
- Mode 0: IRQ stays high until CTRL/PRESET write; Enable reads 0 one edge after INT.
- Mode 1: IRQ high exactly one cycle; period P+2 cycles (INT, LOAD, P cycles of CNT).
- Async reset mid-count: all outputs 0 immediately, no residual IRQ after deassert.

## Configuration
- `TIMER_MODE1_EN` defined: Mode 1 auto-reload as above.
- Undefined: Mode field still stored/read back, but all modes behave as Mode 0 (INT always -> IDLE, Enable cleared, IRQ held).

## Test plan
- Reset: assert reset mid-count with COUNT=3 -> COUNT=0, CTRL=0, IRQ=0 asynchronously; reads of Addr 0/1/2 return 0.
- Mode 0: PRESET=5, CTRL=0x9 -> IRQ rises 7 edges after CTRL write, COUNT=0, CTRL reads 0x8; write CTRL=0x8 -> IRQ drops next cycle.
- Mode 1 (TIMER_MODE1_EN): PRESET=3, CTRL=0xB -> IRQ one-cycle pulses every 5 cycles, COUNT sequence 3,2,1,0 repeating; undefined macro -> single held IRQ, Enable cleared.
- Stop/resume: PRESET=10, enable, clear Enable when COUNT=6 -> COUNT holds 6, IRQ=0; re-enable -> reload to 10 via LOAD.
- PRESET=0 and IM=0: CTRL=0x1 -> INT after 3 edges, IRQ stays 0, irq_flag set; writing CTRL=0x8 clears flag, IRQ stays 0.
- Writes to COUNT (0x1234) and Addr 3 -> no state change, Addr 3 reads 0; CTRL write 0xFFFFFFFF reads back 0xF.
